// File: rtl/ms_timer.sv
// Millisecond countdown timer driven by an external free-running millisecond count.
// One-shot or periodic expiry with a stretched irq pulse, sticky done flag and expiry timestamp.
module ms_timer #(
    parameter int unsigned IRQ_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] millis,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] IRQ_LEN = 8'(IRQ_CYCLES);

    state_t      state;
    state_t      stateNext;
    logic [31:0] millisQ;
    logic [31:0] period;
    logic [31:0] remain;
    logic [31:0] remainNext;
    logic [31:0] snapshot;
    logic        periodic;
    logic        done;
    logic        tick;
    logic        expire;
    logic        ctrlWe;
    logic        running;
    logic [7:0]  irqCnt;

    assign tick    = (millis != millisQ);
    assign ctrlWe  = we && (addr == 2'd1);
    assign running = (state == RUN);
    assign irq     = (irqCnt != 8'd0);

    // A CTRL write wins over a tick in the same cycle; that tick is simply dropped.
    always_comb begin
        stateNext  = state;
        remainNext = remain;
        expire     = 1'b0;
        if (ctrlWe) begin
            if (wdata[2]) begin
                stateNext = IDLE;
            end else if (wdata[0]) begin
                if (period != 32'd0) begin
                    remainNext = period;
                    stateNext  = RUN;
                end else if (state == RUN) begin
                    remainNext = 32'd0;
                    stateNext  = IDLE;
                end
            end
        end else if ((state == RUN) && tick) begin
            if (remain > 32'd1) begin
                remainNext = remain - 32'd1;
            end else begin
                expire = 1'b1;
                if (periodic && (period != 32'd0)) begin
                    remainNext = period;
                end else begin
                    remainNext = 32'd0;
                    stateNext  = IDLE;
                end
            end
        end
    end

    // The snapshot takes the count that millisQ adopts at this edge, i.e. the value that caused the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            millisQ  <= millis;
            state    <= IDLE;
            remain   <= 32'd0;
            period   <= 32'd0;
            periodic <= 1'b0;
            done     <= 1'b0;
            snapshot <= 32'd0;
            irqCnt   <= 8'd0;
            rdata    <= 32'd0;
        end else begin
            millisQ <= millis;
            state   <= stateNext;
            remain  <= remainNext;
            if (we && (addr == 2'd0)) begin
                period <= wdata;
            end
            if (ctrlWe) begin
                periodic <= wdata[1];
            end
            if (expire) begin
                done <= 1'b1;
            end else if (re && (addr == 2'd2)) begin
                done <= 1'b0;
            end
            if (expire) begin
                snapshot <= millis;
            end
            if (expire) begin
                irqCnt <= IRQ_LEN;
            end else if (irqCnt != 8'd0) begin
                irqCnt <= irqCnt - 8'd1;
            end
            if (re) begin
                case (addr)
                    2'd0:    rdata <= period;
                    2'd1:    rdata <= remain;
                    2'd2:    rdata <= {29'd0, done, periodic, running};
                    default: rdata <= snapshot;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ms_timer.sv
// Directed bench for ms_timer: each task drives one scenario and compares against hand-computed values.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ms_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] millis;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad = 0;
    int irqSeen = 0;

    ms_timer #(.IRQ_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .millis(millis),
        .we(we),
        .re(re),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq === 1'b1) irqSeen++;
    end

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
    endtask

    task automatic bump();
        millis = millis + 32'd1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), d);
            total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        write_reg(2'd0, 32'd3);
        write_reg(2'd1, 32'h1);
        read_reg(2'd1, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL oneshot_load: got %h want 3", d); end
        irqSeen = 0;
        for (int i = 1; i <= 3; i++) begin
            idle(9);
            bump();
            total++;
            if (irq !== (i == 3)) begin bad++; $display("FAIL oneshot_irq_tick%0d: got %b want %b", i, irq, (i == 3)); end
        end
        idle(10);
        total++; if (irqSeen != 4) begin bad++; $display("FAIL oneshot_width: got %0d want 4", irqSeen); end
        read_reg(2'd1, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL oneshot_remain: got %h want 0", d); end
        read_reg(2'd2, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL oneshot_status1: got %h want 4", d); end
        read_reg(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL oneshot_status2: got %h want 0", d); end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        write_reg(2'd0, 32'd2);
        write_reg(2'd1, 32'h3);
        irqSeen = 0;
        for (int i = 1; i <= 6; i++) begin
            idle(9);
            bump();
            total++;
            if (irq !== (i % 2 == 0)) begin bad++; $display("FAIL periodic_irq_tick%0d: got %b want %b", i, irq, (i % 2 == 0)); end
            read_reg(2'd1, d);
            total++;
            if (d !== ((i % 2 == 0) ? 32'd2 : 32'd1)) begin bad++; $display("FAIL periodic_remain_tick%0d: got %h", i, d); end
            if (i % 2 == 0) begin
                read_reg(2'd3, d);
                total++; if (d !== millis) begin bad++; $display("FAIL periodic_snap_tick%0d: got %h want %h", i, d, millis); end
            end
        end
        idle(6);
        total++; if (irqSeen != 12) begin bad++; $display("FAIL periodic_irq_cycles: got %0d want 12", irqSeen); end
        write_reg(2'd1, 32'h4);
        read_reg(2'd2, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL periodic_status: got %h want 4", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        write_reg(2'd0, 32'd1);
        write_reg(2'd1, 32'h3);
        irqSeen = 0;
        bump(); idle(1);
        bump(); idle(1);
        bump();
        idle(12);
        total++; if (irqSeen != 8) begin bad++; $display("FAIL b2b_irq_cycles: got %0d want 8", irqSeen); end
        write_reg(2'd1, 32'h4);
        read_reg(2'd1, d);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL b2b_remain: got %h want 1", d); end
        read_reg(2'd2, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL b2b_status: got %h want 4", d); end
    endtask

    task automatic test_stop();
        logic [31:0] d;
        write_reg(2'd0, 32'd5);
        write_reg(2'd1, 32'h1);
        irqSeen = 0;
        bump(); idle(2);
        bump();
        write_reg(2'd1, 32'h4);
        read_reg(2'd1, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL stop_remain: got %h want 3", d); end
        read_reg(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL stop_status: got %h want 0", d); end
        for (int i = 0; i < 20; i++) begin
            bump(); idle(2);
        end
        total++; if (irqSeen != 0) begin bad++; $display("FAIL stop_no_irq: got %0d want 0", irqSeen); end
        read_reg(2'd1, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL stop_frozen: got %h want 3", d); end
    endtask

    task automatic test_zero_period();
        logic [31:0] d;
        write_reg(2'd0, 32'd0);
        write_reg(2'd1, 32'h1);
        irqSeen = 0;
        read_reg(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL zero_status: got %h want 0", d); end
        bump(); bump(); bump();
        idle(6);
        total++; if (irqSeen != 0) begin bad++; $display("FAIL zero_no_irq: got %0d want 0", irqSeen); end
        read_reg(2'd1, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL zero_remain: got %h want 3", d); end
        write_reg(2'd0, 32'd4);
        write_reg(2'd1, 32'h5);
        read_reg(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL startstop_status: got %h want 0", d); end
        write_reg(2'd1, 32'h1);
        read_reg(2'd2, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL start4_status: got %h want 1", d); end
        read_reg(2'd1, d);
        total++; if (d !== 32'd4) begin bad++; $display("FAIL start4_remain: got %h want 4", d); end
        write_reg(2'd0, 32'd0);
        write_reg(2'd1, 32'h1);
        read_reg(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL restart0_status: got %h want 0", d); end
        read_reg(2'd1, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL restart0_remain: got %h want 0", d); end
    endtask

    task automatic test_ctrl_vs_tick();
        logic [31:0] d;
        write_reg(2'd0, 32'd3);
        write_reg(2'd1, 32'h1);
        bump();
        millis = millis + 32'd1;
        write_reg(2'd1, 32'h1);
        read_reg(2'd1, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL ctrl_tick_remain: got %h want 3", d); end
        bump();
        read_reg(2'd1, d);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL ctrl_tick_next: got %h want 2", d); end
        write_reg(2'd1, 32'h4);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        millis = 32'hFFFF_FFFE;
        idle(2);
        write_reg(2'd0, 32'd2);
        write_reg(2'd1, 32'h1);
        bump();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL wrap_irq_early: got %b want 0", irq); end
        idle(3);
        bump();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL wrap_irq: got %b want 1", irq); end
        read_reg(2'd3, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL wrap_snapshot: got %h want 0", d); end
        read_reg(2'd2, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL wrap_status: got %h want 4", d); end
    endtask

    task automatic test_we_re();
        logic [31:0] d;
        we = 1'b1; re = 1'b1; addr = 2'd0; wdata = 32'd7;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        total++; if (rdata !== 32'd2) begin bad++; $display("FAIL wr_same_cycle: got %h want 2", rdata); end
        read_reg(2'd0, d);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL wr_period: got %h want 7", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        write_reg(2'd0, 32'd2);
        write_reg(2'd1, 32'h3);
        bump(); bump(); bump();
        read_reg(2'd1, d);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL mid_remain: got %h want 1", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_irq_active: got %b want 1", irq); end
        reset = 1'b1;
        millis = millis + 32'd100;
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq_cut: got %b want 0", irq); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL mid_rdata: got %h want 0", rdata); end
        irqSeen = 0;
        idle(5);
        total++; if (irqSeen != 0) begin bad++; $display("FAIL mid_no_irq: got %0d want 0", irqSeen); end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), d);
            total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_reg%0d: got %h want 0", a, d); end
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; re = 1'b0; addr = 2'd0; wdata = 32'd0; millis = 32'd100;
        repeat (3) @(negedge clk);
        test_reset();
        test_oneshot();
        test_periodic();
        test_back_to_back();
        test_stop();
        test_zero_period();
        test_ctrl_vs_tick();
        test_wrap();
        test_we_re();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
